regfile_scoreboard: RTL

//   Parametrised multi-read-port register file with an integrated per-register busy scoreboard.

---
 rtl/regfile_scoreboard.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised register file with NUM_RD combinational read ports and a per-register busy
//   scoreboard. Issue logic reserves a destination register (rsv_en/rsv_sel); write-back writes
//   the register and clears its reservation. flush drops every reservation.
//
//   Ports
//     clock, reset_n            rising-edge clock, synchronous active-low reset
//     wEn, write_sel, write_data  write-back port
//     read_sel, read_data       packed read ports, port k at [k*ADDR_W +: ADDR_W] / [k*DATA_W +: DATA_W]
//     read_busy                 per-port pending-write flag
//     rsv_en, rsv_sel           reservation port
//     flush                     clear all reservations
//     busy_cnt                  registered count of reserved registers (0..DEPTH)
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wEn,
    input  logic [ADDR_W-1:0]        write_sel,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [NUM_RD*ADDR_W-1:0] read_sel,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_sel,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              wr_valid, rsv_valid;

    assign wr_valid  = wEn    && !(ZERO_REG && (write_sel == '0));
    assign rsv_valid = rsv_en && !(ZERO_REG && (rsv_sel == '0));

    // Next-state: flush beats a reservation, a reservation beats the write-back clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_valid) begin
            regs_d[write_sel] = write_data;
            busy_d[write_sel] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_sel] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // Count is taken from the next-state vector so the registered value matches busy_q.
    always_comb begin
        busy_cnt_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // Read ports: a forwarded value is by definition no longer pending.
    always_comb begin
        logic [ADDR_W-1:0] sel;
        logic              fwd;
        read_data = '0;
        read_busy = '0;
        sel       = '0;
        fwd       = 1'b0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            sel = read_sel[k*ADDR_W +: ADDR_W];
            fwd = BYPASS && wr_valid && (write_sel == sel);
            if (ZERO_REG && (sel == '0)) begin
                read_data[k*DATA_W +: DATA_W] = '0;
                read_busy[k]                  = 1'b0;
            end else if (fwd) begin
                read_data[k*DATA_W +: DATA_W] = write_data;
                read_busy[k]                  = 1'b0;
            end else begin
                read_data[k*DATA_W +: DATA_W] = regs_q[sel];
                read_busy[k]                  = busy_q[sel];
            end
        end
    end

endmodule
